// File: rtl/std_cache_pkg.sv
// Shared cache-side types and sizes for the dcache store buffer.
// The store buffer and its FIFO take their geometry from these localparams.
package std_cache_pkg;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned PLEN        = 56;
    localparam int unsigned INDEX_WIDTH = 12;
    localparam int unsigned TAG_WIDTH   = 44;
    localparam int unsigned XLEN        = 64;
    localparam int unsigned SB_PTR_W    = $clog2(DEPTH);

    typedef struct packed {
        logic [PLEN-1:0]     paddr;
        logic [XLEN-1:0]     data;
        logic [XLEN/8-1:0]   be;
        logic [1:0]          size;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE,
        SB_TAG
    } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Generic circular FIFO with occupancy count, per-slot valid flags and a
// flattened view of all slots so the owner can search the whole buffer.
module sb_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [PTR_W:0]         count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [DEPTH*WIDTH-1:0] entries_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] slot_offs [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign count_o  = count_q;
    assign rdata_o  = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + (PTR_W+1)'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_offs[i] = PTR_W'(i) - rd_ptr_q;
            valid_o[i]   = ({1'b0, slot_offs[i]} < count_q);
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign entries_o[g*WIDTH +: WIDTH] = mem_q[g];
    end

endmodule

// File: rtl/std_dcache_store_buffer.sv
// Commit-ordered store buffer feeding the dcache two-phase store port
// (index+data with req/gnt, then tag one cycle later), plus load alias match.
module std_dcache_store_buffer
    import std_cache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [PLEN-1:0]        push_paddr_i,
    input  logic [XLEN-1:0]        push_data_i,
    input  logic [XLEN/8-1:0]      push_be_i,
    input  logic [1:0]             push_size_i,
    input  logic [11:0]            page_offset_i,
    output logic                   page_offset_matches_o,
    output logic                   empty_o,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [INDEX_WIDTH-1:0] address_index_o,
    output logic [TAG_WIDTH-1:0]   address_tag_o,
    output logic                   tag_valid_o,
    output logic                   we_o,
    output logic [XLEN-1:0]        wdata_o,
    output logic [XLEN/8-1:0]      be_o,
    output logic [1:0]             size_o
);

    localparam int unsigned ENTRY_W   = $bits(sb_entry_t);
    localparam int unsigned PADDR_LSB = ENTRY_W - PLEN;

    sb_state_e                state_q;
    sb_state_e                state_d;
    sb_entry_t                push_entry;
    sb_entry_t                head;
    logic [ENTRY_W-1:0]       head_raw;
    logic [DEPTH*ENTRY_W-1:0] entries_flat;
    logic [DEPTH-1:0]         entry_valid;
    logic [SB_PTR_W:0]        count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [PLEN-1:3]          inflight_q;
    logic                     unused_bits;

    assign push_entry   = '{paddr: push_paddr_i, data: push_data_i, be: push_be_i, size: push_size_i};
    assign push_ready_o = !fifo_full;
    assign push         = push_valid_i && push_ready_o;
    assign pop          = (state_q == SB_TAG);
    assign head         = head_raw;
    assign empty_o      = fifo_empty && (state_q == SB_IDLE);
    assign unused_bits  = ^{entries_flat, count, page_offset_i[2:0]};

    sb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   (push_entry),
        .rdata_o   (head_raw),
        .count_o   (count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .valid_o   (entry_valid),
        .entries_o (entries_flat)
    );

    // The granted address is captured so the tag phase does not depend on the head slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SB_IDLE;
            inflight_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SB_IDLE && req_o && gnt_i) inflight_q <= head.paddr[PLEN-1:3];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: if (req_o && gnt_i) state_d = SB_TAG;
            SB_TAG:  state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
    end

    always_comb begin
        req_o           = 1'b0;
        we_o            = 1'b0;
        tag_valid_o     = 1'b0;
        address_index_o = '0;
        address_tag_o   = '0;
        wdata_o         = '0;
        be_o            = '0;
        size_o          = '0;
        case (state_q)
            SB_IDLE: begin
                req_o = !fifo_empty;
                if (req_o) begin
                    we_o            = 1'b1;
                    address_index_o = head.paddr[INDEX_WIDTH-1:0];
                    wdata_o         = head.data;
                    be_o            = head.be;
                    size_o          = head.size;
                end
            end
            SB_TAG: begin
                tag_valid_o   = 1'b1;
                address_tag_o = inflight_q[INDEX_WIDTH +: TAG_WIDTH];
            end
            default: ;
        endcase
    end

    // The in-flight store stays visible to loads until its tag phase completes.
    always_comb begin
        page_offset_matches_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entry_valid[i] &&
                entries_flat[i*ENTRY_W + PADDR_LSB + 3 +: 9] == page_offset_i[11:3])
                page_offset_matches_o = 1'b1;
        end
        if (state_q == SB_TAG && inflight_q[11:3] == page_offset_i[11:3])
            page_offset_matches_o = 1'b1;
    end

endmodule

// File: tb/tb_std_dcache_store_buffer.sv
// Directed plus randomized bench for the dcache store buffer, checked against
// a queue-based model of the commit-ordered two-phase store protocol.
module tb_std_dcache_store_buffer;

    localparam int SB_DEPTH = 4;

    typedef struct {
        logic [55:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
    } store_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [55:0] push_paddr_i;
    logic [63:0] push_data_i;
    logic [7:0]  push_be_i;
    logic [1:0]  push_size_i;
    logic [11:0] page_offset_i;
    logic        page_offset_matches_o;
    logic        empty_o;
    logic        req_o;
    logic        gnt_i;
    logic [11:0] address_index_o;
    logic [43:0] address_tag_o;
    logic        tag_valid_o;
    logic        we_o;
    logic [63:0] wdata_o;
    logic [7:0]  be_o;
    logic [1:0]  size_o;

    store_t model_q[$];
    store_t tag_entry;
    logic   in_tag = 1'b0;
    logic   exp_req;
    logic   exp_ready;
    int     total = 0;
    int     bad = 0;

    std_dcache_store_buffer dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .push_valid_i          (push_valid_i),
        .push_ready_o          (push_ready_o),
        .push_paddr_i          (push_paddr_i),
        .push_data_i           (push_data_i),
        .push_be_i             (push_be_i),
        .push_size_i           (push_size_i),
        .page_offset_i         (page_offset_i),
        .page_offset_matches_o (page_offset_matches_o),
        .empty_o               (empty_o),
        .req_o                 (req_o),
        .gnt_i                 (gnt_i),
        .address_index_o       (address_index_o),
        .address_tag_o         (address_tag_o),
        .tag_valid_o           (tag_valid_o),
        .we_o                  (we_o),
        .wdata_o               (wdata_o),
        .be_o                  (be_o),
        .size_o                (size_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int   n = model_q.size();
        logic exp_empty;
        logic exp_match;
        exp_req   = !in_tag && (n != 0);
        exp_ready = (n < SB_DEPTH);
        exp_empty = (n == 0) && !in_tag;
        exp_match = 1'b0;
        foreach (model_q[k])
            if (model_q[k].paddr[11:3] == page_offset_i[11:3]) exp_match = 1'b1;
        if (in_tag && tag_entry.paddr[11:3] == page_offset_i[11:3]) exp_match = 1'b1;
        check("push_ready", push_ready_o, exp_ready);
        check("req", req_o, exp_req);
        check("empty", empty_o, exp_empty);
        check("match", page_offset_matches_o, exp_match);
        check("tag_valid", tag_valid_o, in_tag);
        if (exp_req) begin
            check("we", we_o, 1'b1);
            check("index", address_index_o, model_q[0].paddr[11:0]);
            check("wdata", wdata_o, model_q[0].data);
            check("be", be_o, model_q[0].be);
            check("size", size_o, model_q[0].size);
        end
        if (in_tag) check("tag", address_tag_o, tag_entry.paddr[55:12]);
    endtask

    task automatic applyStimulus(input logic pv, input logic [55:0] pa, input logic [63:0] pd,
                                 input logic [7:0] pb, input logic [1:0] ps, input logic g,
                                 input logic [11:0] po);
        store_t s;
        push_valid_i  = pv;
        push_paddr_i  = pa;
        push_data_i   = pd;
        push_be_i     = pb;
        push_size_i   = ps;
        gnt_i         = g;
        page_offset_i = po;
        #2;
        checkOutput();
        @(posedge clk_i);
        if (rst_i) begin
            model_q.delete();
            in_tag = 1'b0;
        end else begin
            if (in_tag) begin
                void'(model_q.pop_front());
                in_tag = 1'b0;
            end else if (exp_req && g) begin
                in_tag    = 1'b1;
                tag_entry = model_q[0];
            end
            if (pv && exp_ready) begin
                s.paddr = pa; s.data = pd; s.be = pb; s.size = ps;
                model_q.push_back(s);
            end
        end
        #1;
    endtask

    initial begin
        logic [63:0] r;
        logic [11:0] po;
        rst_i = 1'b1;
        push_valid_i = 0; push_paddr_i = 0; push_data_i = 0;
        push_be_i = 0; push_size_i = 0; gnt_i = 0; page_offset_i = 0;
        @(posedge clk_i); #1;
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h000);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h000);
        rst_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h000);

        $display("[TB] single store");
        applyStimulus(1, 56'h8000_1238, 64'hDEAD_BEEF, 8'h0F, 2'd2, 1, 12'h000);
        check("single_index", address_index_o, 12'h238);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 1, 12'h238);

        $display("[TB] fill, stall, drain");
        for (int k = 0; k < 5; k++)
            applyStimulus(1, 56'h100 * (k + 1) + 56'h8, 64'h1111 * (k + 1), 8'hFF, 2'd3, 0, 12'h000);
        check("full_ready", push_ready_o, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 0, 12'h300);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 1, 12'h200);

        $display("[TB] push during pop");
        applyStimulus(1, 56'hA_0010, 64'hA0, 8'h01, 2'd0, 0, 12'h000);
        applyStimulus(1, 56'hB_0020, 64'hB0, 8'h03, 2'd1, 0, 12'h000);
        for (int k = 0; k < 8; k++)
            applyStimulus(k[0], 56'hC_0000 + 56'h40 * k, 64'hC0 + k, 8'hF0, 2'd2, 1, 12'h020);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0, 1, 12'h000);

        $display("[TB] load alias");
        applyStimulus(1, 56'h1_0040, 64'h55, 8'hFF, 2'd3, 0, 12'h044);
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h044);
        check("alias_hit", page_offset_matches_o, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h048);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h044);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h044);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h044);

        $display("[TB] reset mid-op");
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 56'h2_0000 + 56'h8 * k, 64'h77 + k, 8'hFF, 2'd3, 0, 12'h000);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h000);
        page_offset_i = 12'h000;
        #1;
        check("pre_rst_tag", tag_valid_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("rst_req", req_o, 1'b0);
        check("rst_tag_valid", tag_valid_o, 1'b0);
        check("rst_empty", empty_o, 1'b1);
        check("rst_ready", push_ready_o, 1'b1);
        check("rst_match", page_offset_matches_o, 1'b0);
        model_q.delete();
        in_tag = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 1, 12'h000);

        $display("[TB] random");
        for (int n = 0; n < 400; n++) begin
            r = {$urandom, $urandom};
            po = 12'($urandom);
            if (model_q.size() != 0 && $urandom_range(0, 1) == 1)
                po = model_q[$urandom_range(0, model_q.size() - 1)].paddr[11:0] ^ 12'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), r[55:0], {$urandom, $urandom}, 8'($urandom),
                          2'($urandom), 1'($urandom_range(0, 2) != 0), po);
        end
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 1, 12'h000);
        check("final_empty", empty_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
